// File: rtl/ahb_aes_host_driver.sv
// AHB-Lite initiator that loads keys and data blocks into the AES accelerator,
// polls its status register and returns the 128-bit result to a local client.
module ahb_aes_host_driver #(
  parameter logic [31:0] KEY_ADDR   = 32'h0000_0010,
  parameter logic [31:0] DATA_ADDR  = 32'h0000_0000,
  parameter logic [31:0] RES_ADDR   = 32'h0000_0020,
  parameter logic [31:0] STAT_ADDR  = 32'h0000_0030,
  parameter int unsigned RDY_BIT    = 0,
  parameter int unsigned POLL_LIMIT = 255
) (
  input  logic         HCLK,
  input  logic         HRESETn,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic         req_is_key,
  input  logic [127:0] req_data,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [127:0] rsp_data,
  output logic         err_pulse,
  output logic         tmo_pulse,
  output logic [31:0]  HADDR,
  output logic [31:0]  HWDATA,
  output logic [1:0]   HTRANS,
  output logic         HWRITE,
  output logic [2:0]   HSIZE,
  output logic [2:0]   HBURST,
  output logic [3:0]   HPROT,
  input  logic [31:0]  HRDATA,
  input  logic         HREADY,
  input  logic [1:0]   HRESP
);

  typedef enum logic [2:0] {
    S_IDLE, S_WADDR, S_WDATA, S_PADDR, S_PDATA, S_RADDR, S_RDATA, S_RESP
  } state_t;

  localparam logic [1:0] TR_IDLE   = 2'b00;
  localparam logic [1:0] TR_NONSEQ = 2'b10;
  localparam logic [7:0] POLL_MAX  = 8'(POLL_LIMIT);

  state_t       state, state_nxt;
  logic [127:0] req_lat;
  logic         is_key;
  logic [1:0]   idx;
  logic [7:0]   poll_cnt;
  logic [31:0]  req_word;
  logic [31:0]  word_off;
  logic [31:0]  wr_base;
  logic         bus_err;
  logic         err_evt;
  logic         tmo_evt;

  assign HSIZE    = 3'b010;
  assign HBURST   = 3'b000;
  assign HPROT    = 4'b0011;
  assign bus_err  = (HRESP != 2'b00);
  assign word_off = {28'd0, idx, 2'b00};
  assign wr_base  = is_key ? KEY_ADDR : DATA_ADDR;

  always_comb begin
    req_word = '0;
    unique case (idx)
      2'd0: req_word = req_lat[127:96];
      2'd1: req_word = req_lat[95:64];
      2'd2: req_word = req_lat[63:32];
      2'd3: req_word = req_lat[31:0];
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // Address is held through the data phase so wait states never present a new address.
  always_comb begin
    state_nxt = state;
    HTRANS    = TR_IDLE;
    HWRITE    = 1'b0;
    HADDR     = '0;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    err_evt   = 1'b0;
    tmo_evt   = 1'b0;
    unique case (state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nxt = S_WADDR;
      end
      S_WADDR: begin
        HTRANS = TR_NONSEQ;
        HWRITE = 1'b1;
        HADDR  = wr_base + word_off;
        if (HREADY) state_nxt = S_WDATA;
      end
      S_WDATA: begin
        HWRITE = 1'b1;
        HADDR  = wr_base + word_off;
        if (HREADY) begin
          if (bus_err) begin
            err_evt   = 1'b1;
            state_nxt = S_IDLE;
          end else if (idx == 2'd3) begin
            state_nxt = is_key ? S_IDLE : S_PADDR;
          end else begin
            state_nxt = S_WADDR;
          end
        end
      end
      S_PADDR: begin
        HTRANS = TR_NONSEQ;
        HADDR  = STAT_ADDR;
        if (HREADY) state_nxt = S_PDATA;
      end
      S_PDATA: begin
        HADDR = STAT_ADDR;
        if (HREADY) begin
          if (bus_err) begin
            err_evt   = 1'b1;
            state_nxt = S_IDLE;
          end else if (HRDATA[RDY_BIT]) begin
            state_nxt = S_RADDR;
          end else if (poll_cnt + 8'd1 == POLL_MAX) begin
            tmo_evt   = 1'b1;
            state_nxt = S_IDLE;
          end else begin
            state_nxt = S_PADDR;
          end
        end
      end
      S_RADDR: begin
        HTRANS = TR_NONSEQ;
        HADDR  = RES_ADDR + word_off;
        if (HREADY) state_nxt = S_RDATA;
      end
      S_RDATA: begin
        HADDR = RES_ADDR + word_off;
        if (HREADY) begin
          if (bus_err) begin
            err_evt   = 1'b1;
            state_nxt = S_IDLE;
          end else if (idx == 2'd3) begin
            state_nxt = S_RESP;
          end else begin
            state_nxt = S_RADDR;
          end
        end
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      req_lat   <= '0;
      is_key    <= 1'b0;
      idx       <= '0;
      poll_cnt  <= '0;
      HWDATA    <= '0;
      rsp_data  <= '0;
      err_pulse <= 1'b0;
      tmo_pulse <= 1'b0;
    end else begin
      err_pulse <= err_evt;
      tmo_pulse <= tmo_evt;
      unique case (state)
        S_IDLE: begin
          if (req_valid) begin
            req_lat  <= req_data;
            is_key   <= req_is_key;
            idx      <= '0;
            poll_cnt <= '0;
          end
        end
        S_WADDR: if (HREADY) HWDATA <= req_word;
        // idx wraps 3 -> 0 here, which is exactly the start index for the result reads.
        S_WDATA: if (HREADY) idx <= idx + 2'd1;
        S_PDATA: begin
          if (HREADY && !bus_err && !HRDATA[RDY_BIT]) poll_cnt <= poll_cnt + 8'd1;
        end
        S_RDATA: begin
          if (HREADY) begin
            if (bus_err) begin
              rsp_data <= '0;
            end else begin
              unique case (idx)
                2'd0: rsp_data[127:96] <= HRDATA;
                2'd1: rsp_data[95:64]  <= HRDATA;
                2'd2: rsp_data[63:32]  <= HRDATA;
                2'd3: rsp_data[31:0]   <= HRDATA;
              endcase
              idx <= idx + 2'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ahb_aes_host_driver.sv
// Scoreboard bench for ahb_aes_host_driver: a behavioural AHB slave feeds the DUT,
// a request-level model predicts bus transfers and client events.
`timescale 1ns/1ps
module tb_ahb_aes_host_driver;
  localparam int unsigned LIMIT  = 4;
  localparam logic [31:0] KEY_A  = 32'h0000_0010;
  localparam logic [31:0] DATA_A = 32'h0000_0000;
  localparam logic [31:0] RES_A  = 32'h0000_0020;
  localparam logic [31:0] STAT_A = 32'h0000_0030;

  logic         HCLK = 1'b0;
  logic         HRESETn;
  logic         req_valid, req_ready, req_is_key;
  logic [127:0] req_data;
  logic         rsp_valid, rsp_ready;
  logic [127:0] rsp_data;
  logic         err_pulse, tmo_pulse;
  logic [31:0]  HADDR, HWDATA, HRDATA;
  logic [1:0]   HTRANS, HRESP;
  logic         HWRITE, HREADY;
  logic [2:0]   HSIZE, HBURST;
  logic [3:0]   HPROT;

  ahb_aes_host_driver #(
    .KEY_ADDR(KEY_A), .DATA_ADDR(DATA_A), .RES_ADDR(RES_A), .STAT_ADDR(STAT_A),
    .RDY_BIT(0), .POLL_LIMIT(LIMIT)
  ) dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .req_valid(req_valid), .req_ready(req_ready), .req_is_key(req_is_key), .req_data(req_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .err_pulse(err_pulse), .tmo_pulse(tmo_pulse),
    .HADDR(HADDR), .HWDATA(HWDATA), .HTRANS(HTRANS), .HWRITE(HWRITE),
    .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT),
    .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
  );

  initial forever #5 HCLK = ~HCLK;

  typedef struct { logic [31:0] addr; logic wr; logic [31:0] data; } xfer_t;
  typedef struct { int kind; logic [127:0] data; } evt_t;   // kind 1=rsp 2=err 3=tmo

  xfer_t exp_xfer[$];
  evt_t  exp_evt[$];
  int total = 0;
  int bad   = 0;

  // per-request slave behaviour
  int          req_id = 0;
  int          cfg_npoll, cfg_err_at, cfg_fix_idx, cfg_fix_n, cfg_wait_max;
  logic [31:0] cfg_res [4];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Request-level model: list of transfers the request should produce and its outcome.
  task automatic push_model(input bit k, input logic [127:0] d);
    xfer_t lst[$];
    xfer_t x;
    evt_t  e;
    int    nreads;
    bit    tmo;
    for (int i = 0; i < 4; i++) begin
      x.addr = (k ? KEY_A : DATA_A) + 32'(4 * i);
      x.wr   = 1'b1;
      x.data = d[127 - 32*i -: 32];
      lst.push_back(x);
    end
    tmo = 1'b0;
    if (!k) begin
      tmo    = (cfg_npoll >= int'(LIMIT));
      nreads = tmo ? int'(LIMIT) : cfg_npoll + 1;
      for (int i = 0; i < nreads; i++) begin
        x.addr = STAT_A; x.wr = 1'b0; x.data = '0;
        lst.push_back(x);
      end
      if (!tmo) begin
        for (int i = 0; i < 4; i++) begin
          x.addr = RES_A + 32'(4 * i); x.wr = 1'b0; x.data = '0;
          lst.push_back(x);
        end
      end
    end
    e.kind = 0;
    e.data = '0;
    if (cfg_err_at >= 0 && cfg_err_at < lst.size()) begin
      while (lst.size() > cfg_err_at + 1) void'(lst.pop_back());
      e.kind = 2;
    end else if (tmo) begin
      e.kind = 3;
    end else if (!k) begin
      e.kind = 1;
      e.data = {cfg_res[0], cfg_res[1], cfg_res[2], cfg_res[3]};
    end
    foreach (lst[i]) exp_xfer.push_back(lst[i]);
    if (e.kind != 0) exp_evt.push_back(e);
  endtask

  task automatic expect_evt(input int kind, input logic [127:0] d);
    evt_t e;
    if (exp_evt.size() == 0) begin
      total++; bad++;
      $display("FAIL unexpected_event: got kind %0d data %h want none", kind, d);
    end else begin
      e = exp_evt.pop_front();
      chk("event_kind", 128'(kind), 128'(e.kind));
      if (kind == 1 && e.kind == 1) chk("rsp_data", d, e.data);
    end
  endtask

  // AHB slave: address phases always ready, data phases with chosen waits / errors.
  initial begin : slave
    int s_idx, s_stat, seen_id, s_waits, s_stage;
    logic [31:0] s_addr, v;
    bit s_write, s_in, s_err;
    HREADY = 1'b1; HRESP = 2'b00; HRDATA = '0; rsp_ready = 1'b0;
    s_in = 1'b0; seen_id = -1; s_idx = 0; s_stat = 0;
    forever begin
      @(negedge HCLK);
      rsp_ready = ($urandom_range(0, 2) == 0);
      if (HRESETn !== 1'b1) begin
        s_in = 1'b0; HREADY = 1'b1; HRESP = 2'b00;
      end else if (s_in) begin
        if (s_err && s_stage == 0) begin
          HREADY = 1'b0; HRESP = 2'b01; s_stage = 1; HRDATA = $urandom;
        end else if (s_err) begin
          HREADY = 1'b1; HRESP = 2'b01; s_in = 1'b0; HRDATA = $urandom;
        end else if (s_waits > 0) begin
          HREADY = 1'b0; HRESP = 2'b00; s_waits--; HRDATA = $urandom;
        end else begin
          v = $urandom;
          if (s_addr == STAT_A) begin
            v[0] = (s_stat >= cfg_npoll);
            s_stat++;
          end else if (!s_write) begin
            v = cfg_res[((s_addr - RES_A) >> 2) & 32'd3];
          end
          HRDATA = v; HREADY = 1'b1; HRESP = 2'b00; s_in = 1'b0;
        end
      end else begin
        HREADY = 1'b1; HRESP = 2'b00;
        if (HTRANS == 2'b10) begin
          if (seen_id != req_id) begin seen_id = req_id; s_idx = 0; s_stat = 0; end
          s_addr  = HADDR;
          s_write = HWRITE;
          s_err   = (s_idx == cfg_err_at);
          s_stage = 0;
          s_waits = (s_idx == cfg_fix_idx) ? cfg_fix_n : int'($urandom_range(0, cfg_wait_max));
          s_idx++;
          s_in = 1'b1;
        end
      end
    end
  end

  // Transfer monitor: pops the expected transfer when each data phase completes.
  initial begin : xfer_mon
    bit in_d, first;
    logic [31:0] a, last_wd;
    logic w;
    xfer_t x;
    in_d = 1'b0;
    forever begin
      @(negedge HCLK); #2;
      if (HRESETn !== 1'b1) begin
        in_d = 1'b0;
      end else if (in_d) begin
        chk("data_phase_htrans", 128'(HTRANS), 128'(2'b00));
        chk("data_phase_haddr", 128'(HADDR), 128'(a));
        if (!first && w) chk("data_phase_hwdata_hold", 128'(HWDATA), 128'(last_wd));
        last_wd = HWDATA;
        first   = 1'b0;
        if (HREADY) begin
          if (exp_xfer.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_xfer: got addr %h write %0b want none", a, w);
          end else begin
            x = exp_xfer.pop_front();
            chk("xfer_addr", 128'(a), 128'(x.addr));
            chk("xfer_write", 128'(w), 128'(x.wr));
            if (x.wr) chk("xfer_wdata", 128'(HWDATA), 128'(x.data));
          end
          in_d = 1'b0;
        end
      end else if (HTRANS == 2'b10 && HREADY) begin
        a = HADDR; w = HWRITE; in_d = 1'b1; first = 1'b1;
        chk("ctrl_const", 128'({HSIZE, HBURST, HPROT}), 128'({3'b010, 3'b000, 4'b0011}));
      end
    end
  end

  // Client-side event monitor.
  initial begin : evt_mon
    logic pv, pr, pe, pt;
    logic [127:0] pd;
    pv = 1'b0; pr = 1'b0; pe = 1'b0; pt = 1'b0; pd = '0;
    forever begin
      @(negedge HCLK); #2;
      if (HRESETn !== 1'b1) begin
        pv = 1'b0; pe = 1'b0; pt = 1'b0;
      end else begin
        if (pv && !pr) begin
          chk("rsp_valid_held", 128'(rsp_valid), 128'(1'b1));
          chk("rsp_data_held", rsp_data, pd);
        end
        if (err_pulse) begin chk("err_pulse_width", 128'(pe), 128'(1'b0)); expect_evt(2, '0); end
        if (tmo_pulse) begin chk("tmo_pulse_width", 128'(pt), 128'(1'b0)); expect_evt(3, '0); end
        if (rsp_valid && rsp_ready) expect_evt(1, rsp_data);
        pv = rsp_valid; pr = rsp_ready; pd = rsp_data; pe = err_pulse; pt = tmo_pulse;
      end
    end
  end

  task automatic set_cfg(input int npoll, input int err_at, input int fix_idx, input int fix_n,
                         input int wmax);
    cfg_npoll = npoll; cfg_err_at = err_at; cfg_fix_idx = fix_idx;
    cfg_fix_n = fix_n; cfg_wait_max = wmax;
  endtask

  task automatic issue(input bit k, input logic [127:0] d);
    int n;
    n = 0;
    @(negedge HCLK); #3;
    while (!req_ready && n < 2000) begin @(negedge HCLK); #3; n++; end
    chk("ready_before_issue", 128'(req_ready), 128'(1'b1));
    req_id++;
    push_model(k, d);
    req_valid = 1'b1; req_is_key = k; req_data = d;
    @(posedge HCLK); #1;
    req_valid = 1'b0; req_is_key = ($urandom_range(0, 1) == 1);
    req_data  = {$urandom, $urandom, $urandom, $urandom};
  endtask

  // Cycles from acceptance until the DUT is idle or presents a response, then drain.
  task automatic wait_done(output int cyc);
    int n;
    cyc = 0;
    do begin @(posedge HCLK); #1; cyc++; end while (!(req_ready || rsp_valid) && cyc < 3000);
    n = 0;
    while (!(req_ready && exp_xfer.size() == 0 && exp_evt.size() == 0) && n < 3000) begin
      @(negedge HCLK); #3; n++;
    end
    if (n >= 3000) begin
      total++; bad++;
      $display("FAIL drain_timeout: got %0d xfers %0d events pending want 0", exp_xfer.size(), exp_evt.size());
      exp_xfer.delete(); exp_evt.delete();
    end
  endtask

  task automatic chk_reset_vals(input string name);
    chk(name, 128'({HTRANS, HADDR, HWDATA, HWRITE, req_ready, rsp_valid, err_pulse, tmo_pulse}),
        128'({2'b00, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0}));
    chk({name, "_rsp_data"}, rsp_data, '0);
  endtask

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog: got no completion want $finish before 600us");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int cyc, n;
    bit found;
    HRESETn = 1'b0; req_valid = 1'b0; req_is_key = 1'b0; req_data = '0;
    set_cfg(0, -1, -1, 0, 0);
    for (int i = 0; i < 4; i++) cfg_res[i] = '0;
    repeat (3) @(posedge HCLK);
    #1 chk_reset_vals("reset_outputs");
    @(negedge HCLK); #3 HRESETn = 1'b1;

    // key load, zero wait states
    set_cfg(0, -1, -1, 0, 0);
    issue(1'b1, 128'h000102030405060708090a0b0c0d0e0f);
    wait_done(cyc);
    chk("key_latency", 128'(cyc), 128'(8));

    // data block: three not-ready polls, then ready
    set_cfg(3, -1, -1, 0, 0);
    cfg_res[0] = 32'hAAAA0001; cfg_res[1] = 32'hAAAA0002;
    cfg_res[2] = 32'hAAAA0003; cfg_res[3] = 32'hAAAA0004;
    issue(1'b0, {$urandom, $urandom, $urandom, $urandom});
    wait_done(cyc);
    chk("data_latency", 128'(cyc), 128'(24));

    // three wait states on the word 2 write
    set_cfg(0, -1, 2, 3, 0);
    issue(1'b0, 128'h11111111_22222222_33333333_44444444);
    wait_done(cyc);

    // error response on the second write
    set_cfg(0, 1, -1, 0, 0);
    issue(1'b0, {$urandom, $urandom, $urandom, $urandom});
    wait_done(cyc);
    chk("ready_after_err", 128'({req_ready, rsp_valid}), 128'(2'b10));

    // status stuck at zero -> timeout after LIMIT reads
    set_cfg(1000, -1, -1, 0, 0);
    issue(1'b0, {$urandom, $urandom, $urandom, $urandom});
    wait_done(cyc);
    chk("ready_after_tmo", 128'({req_ready, rsp_valid}), 128'(2'b10));

    // reset asserted while reading result word 2
    set_cfg(0, -1, -1, 0, 0);
    for (int i = 0; i < 4; i++) cfg_res[i] = $urandom;
    issue(1'b0, {$urandom, $urandom, $urandom, $urandom});
    found = 1'b0; n = 0;
    while (!found && n < 2000) begin
      @(negedge HCLK); #3; n++;
      found = (HTRANS == 2'b10 && HADDR == RES_A + 32'd8);
    end
    chk("reach_result_read", 128'(found), 128'(1'b1));
    HRESETn = 1'b0;
    exp_xfer.delete(); exp_evt.delete();
    #1 chk_reset_vals("mid_reset_outputs");
    @(posedge HCLK); #1 chk_reset_vals("mid_reset_edge_outputs");
    @(negedge HCLK); #3 HRESETn = 1'b1;
    set_cfg(1, -1, -1, 0, 1);
    for (int i = 0; i < 4; i++) cfg_res[i] = $urandom;
    issue(1'b0, {$urandom, $urandom, $urandom, $urandom});
    wait_done(cyc);

    // randomized requests with random waits, polls and errors
    for (int t = 0; t < 40; t++) begin
      set_cfg(int'($urandom_range(0, 5)),
              ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 12)) : -1,
              -1, 0, 2);
      for (int i = 0; i < 4; i++) cfg_res[i] = $urandom;
      issue($urandom_range(0, 1) == 1, {$urandom, $urandom, $urandom, $urandom});
      wait_done(cyc);
    end

    repeat (4) @(negedge HCLK);
    chk("leftover_xfers", 128'(exp_xfer.size()), 128'(0));
    chk("leftover_events", 128'(exp_evt.size()), 128'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
